// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
//   Shared constants and helpers for valid_beat_deserializer.
//   - DEF_WIDTH / DEF_BEATS : default beat width and beats per wide word
//   - cnt_w(beats)          : beat counter width ($clog2(beats))
//   - flush_cnt_t           : filled-beat count type for the default geometry
//                             (0..beats, so $clog2(beats+1) bits)
// -----------------------------------------------------------------------------
package deser_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_BEATS = 4;

    function automatic int cnt_w(input int beats);
        return $clog2(beats);
    endfunction

    typedef logic [$clog2(DEF_BEATS+1)-1:0] flush_cnt_t;

endpackage

// File: rtl/vld_rdy_out_reg.sv
// -----------------------------------------------------------------------------
// vld_rdy_out_reg
//   Width-generic valid/ready holding register.
//   Ports:
//     clk, rst      : clock, asynchronous active-low reset
//     load          : capture load_data this edge (caller only loads when free)
//     load_data     : word to capture
//     out_vld       : held word valid
//     out_data      : held word (kept after transfer, cleared only by reset)
//     out_rdy       : downstream accepts the held word this cycle
//     free          : register can take a new word this edge (empty or draining)
// -----------------------------------------------------------------------------
module vld_rdy_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    input  logic         out_rdy,
    output logic         free
);

    assign free = !out_vld || out_rdy;

    // A load on the same edge as a transfer wins, so back-to-back words
    // keep out_vld high with no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_data <= load_data;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/valid_beat_deserializer.sv
// -----------------------------------------------------------------------------
// valid_beat_deserializer
//   Collects `beats` accepted narrow beats and emits one wide word; beat k
//   lands in out_data[k*width +: width] (first beat in the LSBs). One
//   collection register plus one output holding register, ready/valid on
//   both sides.
//   Ports:
//     clk, rst  : clock, asynchronous active-low reset
//     in_vld    : input beat valid
//     in_data   : input beat
//     in_rdy    : beat accepted this cycle when in_vld && in_rdy
//     out_vld   : wide word valid
//     out_data  : wide word
//     out_rdy   : downstream accepts word this cycle
//   Optional (`define DESER_FLUSH_EN):
//     in_flush  : emit the partial word collected so far (unfilled beats zero)
//     out_cnt   : number of filled beats in the held word (beats for full words)
// -----------------------------------------------------------------------------
module valid_beat_deserializer
    import deser_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int beats = DEF_BEATS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic [width-1:0]         in_data,
    output logic                     in_rdy,
    output logic                     out_vld,
    output logic [width*beats-1:0]   out_data,
    input  logic                     out_rdy
`ifdef DESER_FLUSH_EN
    ,
    input  logic                     in_flush,
    output logic [$clog2(beats+1)-1:0] out_cnt
`endif
);

    localparam int CW = cnt_w(beats);
    localparam int WW = width * beats;
`ifdef DESER_FLUSH_EN
    localparam int FW = $clog2(beats + 1);
    localparam int OW = WW + FW;
`else
    localparam int OW = WW;
`endif
    localparam logic [CW-1:0] LAST = CW'(beats - 1);

    logic [CW-1:0]                 count;
    logic [beats-1:0][width-1:0]   coll;
    logic [beats-1:0][width-1:0]   word;
    logic                          at_last;
    logic                          out_free;
    logic                          beat;
    logic                          load;
    logic [OW-1:0]                 load_data;
    logic [OW-1:0]                 held;

    assign at_last = (count == LAST);
    assign beat    = in_vld && in_rdy;

    // Word as it would look after this edge: slots below count come from the
    // collection register, the current slot from in_data when a beat is
    // taken, the rest zero. For a full word every slot is filled; for a
    // flushed partial word the tail comes out zero without ever clearing coll.
    for (genvar k = 0; k < beats; k++) begin : g_slot
        localparam logic [CW-1:0] K = CW'(k);
        assign word[k] = (beat && count == K) ? in_data :
                         (count > K)          ? coll[k] : '0;
    end

`ifdef DESER_FLUSH_EN
    logic [FW-1:0] filled;
    logic          flush_go;

    // Beats held after this edge's beat (if any) is counted.
    assign filled   = FW'(count) + FW'(beat);
    assign flush_go = in_flush && (filled != '0) && out_free;
    assign load     = (beat && at_last) || flush_go;
    assign load_data = {filled, word};
    // A flush that cannot emit must not let a beat slip in behind it.
    assign in_rdy   = (!at_last || out_free) &&
                      !(in_flush && (count != '0) && !out_free);
    assign {out_cnt, out_data} = held;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= '0;
        else if (beat)
            count <= count + 1'b1;
    end
`else
    assign load      = beat && at_last;
    assign load_data = word;
    assign in_rdy    = !at_last || out_free;
    assign out_data  = held;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (beat)
            count <= at_last ? '0 : count + 1'b1;
    end
`endif

    // Collection register: only the addressed slot moves, so a stalled
    // last beat leaves beats 0..beats-2 in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coll <= '0;
        end else if (beat) begin
            for (int k = 0; k < beats; k++)
                if (count == CW'(k))
                    coll[k] <= in_data;
        end
    end

    vld_rdy_out_reg #(
        .W (OW)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .out_vld   (out_vld),
        .out_data  (held),
        .out_rdy   (out_rdy),
        .free      (out_free)
    );

endmodule
